// File: rtl/mitll_deser_rx.sv
// mitll_deser_rx: serial RSFQ link receiver, start/data/[parity]/stop deframing into a one-entry valid/ready buffer
//   C clock, R sync active-high reset, A serial line (idle 0)
//   Q/Q_VALID/RDY output word buffer handshake
//   ERR_FRAME stop-bit pulse, ERR_OVF sticky overflow, ERR_PAR parity pulse, FRAME_CNT loaded-frame count
//   optional even parity bit enabled by MITLL_DESER_PARITY_EN
module mitll_deser_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic             A,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    input  logic             RDY,
    output logic             ERR_FRAME,
    output logic             ERR_OVF,
    output logic             ERR_PAR,
    output logic [CNT_W-1:0] FRAME_CNT
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t st;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0] cnt;
    logic par_ok;
    logic good;
`ifdef MITLL_DESER_PARITY_EN
    logic par;
    assign par_ok = ~^{sr, par};
`else
    assign par_ok = 1'b1;
    assign ERR_PAR = 1'b0;
`endif
    assign good = ~A & par_ok;
    always_ff @(posedge C) begin
        if (R) begin
            st        <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            Q         <= '0;
            Q_VALID   <= 1'b0;
            ERR_FRAME <= 1'b0;
            ERR_OVF   <= 1'b0;
            FRAME_CNT <= '0;
`ifdef MITLL_DESER_PARITY_EN
            par       <= 1'b0;
            ERR_PAR   <= 1'b0;
`endif
        end else begin
            ERR_FRAME <= 1'b0;
`ifdef MITLL_DESER_PARITY_EN
            ERR_PAR   <= 1'b0;
`endif
            if (Q_VALID && RDY)
                Q_VALID <= 1'b0;
            case (st)
                IDLE: if (A) begin
                    st  <= DATA;
                    cnt <= '0;
                end
                DATA: begin
                    sr[cnt] <= A;
                    cnt     <= cnt + 1'b1;
`ifdef MITLL_DESER_PARITY_EN
                    if (cnt == LAST) st <= PARITY;
`else
                    if (cnt == LAST) st <= STOP;
`endif
                end
`ifdef MITLL_DESER_PARITY_EN
                PARITY: begin
                    par <= A;
                    st  <= STOP;
                end
`endif
                STOP: begin
                    // the stop edge always returns to IDLE, so a 1 here is never a start bit
                    st        <= IDLE;
                    ERR_FRAME <= A;
`ifdef MITLL_DESER_PARITY_EN
                    ERR_PAR   <= ~par_ok;
`endif
                    if (good) begin
                        if (!Q_VALID || RDY) begin
                            Q         <= sr;
                            Q_VALID   <= 1'b1;
                            FRAME_CNT <= FRAME_CNT + 1'b1;
                        end else
                            ERR_OVF <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mitll_deser_rx.sv
// tb_mitll_deser_rx: scoreboard bench for mitll_deser_rx
module tb_mitll_deser_rx;
    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    logic C = 1'b0, R = 1'b1, A = 1'b0, RDY = 1'b0;
    logic [WIDTH-1:0] Q;
    logic Q_VALID, ERR_FRAME, ERR_OVF, ERR_PAR;
    logic [CNT_W-1:0] FRAME_CNT;
    int errors = 0, checks = 0;
    logic [WIDTH-1:0] sb[$];
    logic exp_valid, exp_ovf;
    logic [CNT_W-1:0] exp_cnt;

    mitll_deser_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .C(C), .R(R), .A(A), .Q(Q), .Q_VALID(Q_VALID), .RDY(RDY),
        .ERR_FRAME(ERR_FRAME), .ERR_OVF(ERR_OVF), .ERR_PAR(ERR_PAR), .FRAME_CNT(FRAME_CNT)
    );

    always #5 C = ~C;

    task tick(input logic a, input logic rdy);
        A = a;
        RDY = rdy;
        @(posedge C);
        #1;
    endtask

    task do_reset;
        R = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        R = 1'b0;
        sb.delete();
        exp_valid = 1'b0;
        exp_ovf = 1'b0;
        exp_cnt = '0;
        checks++;
        if ({Q, Q_VALID, ERR_FRAME, ERR_OVF, ERR_PAR, FRAME_CNT} !== '0) begin
            errors++;
            $display("FAIL reset: Q=%h v=%b ef=%b eo=%b ep=%b cnt=%0d required all 0", Q, Q_VALID, ERR_FRAME, ERR_OVF, ERR_PAR, FRAME_CNT);
        end
        A = 1'b0;
        RDY = 1'b0;
    endtask

    task idle_check(input int n, input string name);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
        checks++;
        if (Q_VALID !== exp_valid || FRAME_CNT !== exp_cnt || ERR_OVF !== exp_ovf || (exp_valid && Q !== sb[$])) begin
            errors++;
            $display("FAIL %s: v=%b cnt=%0d ovf=%b Q=%h required v=%b cnt=%0d ovf=%b Q=%h", name, Q_VALID, FRAME_CNT, ERR_OVF, Q,
                     exp_valid, exp_cnt, exp_ovf, exp_valid ? sb[$] : Q);
        end
    endtask

    task send_frame(input logic [WIDTH-1:0] w, input logic stop, input logic par_bit, input logic rdy, input logic gap);
        logic ok, consume, ld, perr;
        logic [WIDTH-1:0] front;
        tick(1'b1, 1'b0);
        for (int i = 0; i < WIDTH; i++) tick(w[i], 1'b0);
`ifdef MITLL_DESER_PARITY_EN
        tick(par_bit, 1'b0);
        perr = ^w ^ par_bit;
`else
        perr = 1'b0;
`endif
        ok = !stop && !perr;
        checks++;
        if (Q_VALID !== exp_valid) begin
            errors++;
            $display("FAIL pre_stop_valid: got %b required %b", Q_VALID, exp_valid);
        end
        consume = exp_valid && rdy;
        if (consume) begin
            front = sb.pop_front();
            checks++;
            if (Q !== front) begin
                errors++;
                $display("FAIL consume_q: got %h required %h", Q, front);
            end
        end
        ld = ok && (!exp_valid || rdy);
        if (ld) begin
            sb.push_back(w);
            exp_cnt = exp_cnt + 1'b1;
            exp_valid = 1'b1;
        end else if (consume)
            exp_valid = 1'b0;
        if (ok && !ld) exp_ovf = 1'b1;
        tick(stop, rdy);
        checks++;
        if (Q_VALID !== exp_valid || FRAME_CNT !== exp_cnt || ERR_OVF !== exp_ovf) begin
            errors++;
            $display("FAIL stop_state: v=%b cnt=%0d ovf=%b required v=%b cnt=%0d ovf=%b", Q_VALID, FRAME_CNT, ERR_OVF, exp_valid, exp_cnt, exp_ovf);
        end
        checks++;
        if (ERR_FRAME !== stop || ERR_PAR !== perr) begin
            errors++;
            $display("FAIL stop_flags: ef=%b ep=%b required ef=%b ep=%b", ERR_FRAME, ERR_PAR, stop, perr);
        end
        if (exp_valid) begin
            checks++;
            if (Q !== sb[$]) begin
                errors++;
                $display("FAIL stop_q: got %h required %h", Q, sb[$]);
            end
        end
        if (gap) begin
            tick(1'b0, 1'b0);
            checks++;
            if (ERR_FRAME !== 1'b0 || ERR_PAR !== 1'b0) begin
                errors++;
                $display("FAIL pulse_clear: ef=%b ep=%b required 0 0", ERR_FRAME, ERR_PAR);
            end
        end
    endtask

    task drain;
        logic [WIDTH-1:0] front;
        checks++;
        if (Q_VALID !== exp_valid) begin
            errors++;
            $display("FAIL drain_valid: got %b required %b", Q_VALID, exp_valid);
        end
        if (exp_valid) begin
            front = sb.pop_front();
            checks++;
            if (Q !== front) begin
                errors++;
                $display("FAIL drain_q: got %h required %h", Q, front);
            end
        end
        tick(1'b0, 1'b1);
        exp_valid = 1'b0;
        checks++;
        if (Q_VALID !== 1'b0 || FRAME_CNT !== exp_cnt) begin
            errors++;
            $display("FAIL drain_after: v=%b cnt=%0d required v=0 cnt=%0d", Q_VALID, FRAME_CNT, exp_cnt);
        end
        RDY = 1'b0;
    endtask

    task test_reset;
        do_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        do_reset();
        idle_check(12, "reset_discard");
    endtask

    task test_good_frame;
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (Q !== 8'hA5 || FRAME_CNT !== 2'd1) begin
            errors++;
            $display("FAIL good_frame: Q=%h cnt=%0d required a5 1", Q, FRAME_CNT);
        end
        idle_check(5, "good_hold");
        drain();
        drain();
    endtask

    task test_frame_error;
        do_reset();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_check(12, "frame_err_idle");
    endtask

    task test_overflow_drain;
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_check(4, "ovf_sticky");
        drain();
        idle_check(2, "ovf_after_drain");
    endtask

    task test_same_edge;
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (Q !== 8'h3C || Q_VALID !== 1'b1 || ERR_OVF !== 1'b0 || FRAME_CNT !== 2'd2) begin
            errors++;
            $display("FAIL same_edge: Q=%h v=%b ovf=%b cnt=%0d required 3c 1 0 2", Q, Q_VALID, ERR_OVF, FRAME_CNT);
        end
        drain();
    endtask

    task test_parity;
`ifdef MITLL_DESER_PARITY_EN
        do_reset();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_check(3, "parity_drop");
`endif
    endtask

    task test_wrap;
        logic [WIDTH-1:0] w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w = WIDTH'($urandom);
            send_frame(w, 1'b0, ^w, 1'b1, i[0]);
        end
        checks++;
        if (FRAME_CNT !== 2'd0 || Q_VALID !== 1'b1) begin
            errors++;
            $display("FAIL wrap: cnt=%0d v=%b required 0 1", FRAME_CNT, Q_VALID);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_frame_error();
        test_overflow_drain();
        test_same_edge();
        test_parity();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
